// File: rtl/softmax_ctrl_pkg.sv
// Shared types and constants for the softmax pass sequencer.
// Provides state/phase encodings plus latency clamping used when sizing delay lines.
package softmax_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAX,
      ST_SUM,
      ST_LN,
      ST_NORM,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_MAX  = 2'd1,
      PH_SUM  = 2'd2,
      PH_NORM = 2'd3
   } phase_e;

   localparam int LAT_MIN  = 0;
   localparam int LAT_MAX  = 7;
   localparam int CNT_XTRA = 4;

   function automatic int clamp_lat(input int lat);
      if (lat > LAT_MAX) return LAT_MAX;
      if (lat < LAT_MIN) return LAT_MIN;
      return lat;
   endfunction

   // LN and DONE deliberately report idle: no RAM traffic happens in them.
   function automatic phase_e state_phase(input state_e s);
      case (s)
         ST_MAX:  return PH_MAX;
         ST_SUM:  return PH_SUM;
         ST_NORM: return PH_NORM;
         default: return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register cleared by synchronous reset; shifts every cycle.
// DEPTH cycles of latency, zero depth is a straight wire; no backpressure.
module ctrl_delay_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign dout = din;
      end else begin : g_pipe
         logic [W-1:0] pipe_q [DEPTH];
         logic [W-1:0] pipe_d [DEPTH];

         always_comb begin
            pipe_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  pipe_q[i] <= pipe_d[i];
               end
            end
         end

         assign dout = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Address/enable sequencer for the 4-lane softmax: MAX, SUM, one ln launch, NORM, DONE.
// Run of n chunks takes 3n+5+lat cycles; start is ignored while busy, no data backpressure.
module softmax_seq_ctrl
   import softmax_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int RD_LAT  = 1,
   parameter int SUM_LAT = 2,
   parameter int LN_LAT  = 1,
   parameter int OUT_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_chunks,
   output logic              busy,
   output logic              done,
   output logic [1:0]        phase,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              max_clr,
   output logic              max_en,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              ln_start,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam int CW     = ADDR_W + CNT_XTRA;
   localparam int MAX_L  = clamp_lat(RD_LAT);
   localparam int SUM_L  = clamp_lat(RD_LAT) + clamp_lat(SUM_LAT);
   localparam int LN_L   = clamp_lat(LN_LAT);
   localparam int NORM_L = clamp_lat(RD_LAT) + clamp_lat(OUT_LAT);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic [CW-1:0]     last_cnt;
   logic              rd_act;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   phase_e            phase_q, phase_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              max_clr_q, max_clr_d;
   logic              acc_clr_q, acc_clr_d;
   logic              ln_start_q, ln_start_d;

   // Final count of the current phase: read window plus the pipeline drain.
   always_comb begin
      last_cnt = '0;
      case (state_q)
         ST_MAX:  last_cnt = CW'(n_q) + CW'(MAX_L)  - CW'(1);
         ST_SUM:  last_cnt = CW'(n_q) + CW'(SUM_L)  - CW'(1);
         ST_LN:   last_cnt = CW'(LN_L);
         ST_NORM: last_cnt = CW'(n_q) + CW'(NORM_L) - CW'(1);
         default: last_cnt = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      n_d     = n_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) begin
               n_d     = num_chunks;
               state_d = (num_chunks == '0) ? ST_DONE : ST_MAX;
            end
         end
         ST_MAX:  if (cnt_q == last_cnt) begin state_d = ST_SUM;  cnt_d = '0; end
         ST_SUM:  if (cnt_q == last_cnt) begin state_d = ST_LN;   cnt_d = '0; end
         ST_LN:   if (cnt_q == last_cnt) begin state_d = ST_NORM; cnt_d = '0; end
         ST_NORM: if (cnt_q == last_cnt) begin state_d = ST_DONE; cnt_d = '0; end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they register cleanly.
      rd_act     = ((state_d == ST_MAX) || (state_d == ST_SUM) || (state_d == ST_NORM))
                   && (cnt_d < CW'(n_d));
      rd_en_d    = rd_act;
      rd_addr_d  = rd_act ? cnt_d[ADDR_W-1:0] : '0;
      max_clr_d  = (state_d == ST_MAX) && (cnt_d == '0);
      acc_clr_d  = (state_d == ST_SUM) && (cnt_d == '0);
      ln_start_d = (state_d == ST_LN)  && (cnt_d == '0);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      phase_d    = state_phase(state_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         n_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         phase_q    <= PH_IDLE;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         max_clr_q  <= 1'b0;
         acc_clr_q  <= 1'b0;
         ln_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         phase_q    <= phase_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         max_clr_q  <= max_clr_d;
         acc_clr_q  <= acc_clr_d;
         ln_start_q <= ln_start_d;
      end
   end

   logic              max_tap, acc_tap, wr_tap;
   logic [ADDR_W-1:0] wr_addr_tap;

   assign max_tap     = rd_en_q && (phase_q == PH_MAX);
   assign acc_tap     = rd_en_q && (phase_q == PH_SUM);
   assign wr_tap      = rd_en_q && (phase_q == PH_NORM);
   assign wr_addr_tap = wr_tap ? rd_addr_q : '0;

   ctrl_delay_line #(.W(1), .DEPTH(MAX_L)) u_max_dly (
      .clk(clk), .reset(reset), .din(max_tap), .dout(max_en)
   );
   ctrl_delay_line #(.W(1), .DEPTH(SUM_L)) u_acc_dly (
      .clk(clk), .reset(reset), .din(acc_tap), .dout(acc_en)
   );
   ctrl_delay_line #(.W(1), .DEPTH(NORM_L)) u_wr_dly (
      .clk(clk), .reset(reset), .din(wr_tap), .dout(wr_en)
   );
   ctrl_delay_line #(.W(ADDR_W), .DEPTH(NORM_L)) u_wra_dly (
      .clk(clk), .reset(reset), .din(wr_addr_tap), .dout(wr_addr)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign phase    = phase_q;
   assign rd_en    = rd_en_q;
   assign rd_addr  = rd_addr_q;
   assign max_clr  = max_clr_q;
   assign acc_clr  = acc_clr_q;
   assign ln_start = ln_start_q;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl: per-cycle vector table plus hand-written corner sequences.
// A second instance with SUM_LAT=4, LN_LAT=3 shares the inputs for the latency-scaling case.
module tb_softmax_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] num_chunks;

   logic       busy, done, rd_en, max_clr, max_en, acc_clr, acc_en, ln_start, wr_en;
   logic [1:0] phase;
   logic [3:0] rd_addr, wr_addr;

   logic       busy5, done5, rd_en5, max_clr5, max_en5, acc_clr5, acc_en5, ln_start5, wr_en5;
   logic [1:0] phase5;
   logic [3:0] rd_addr5, wr_addr5;

   always #5 clk = ~clk;

   softmax_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks),
      .busy(busy), .done(done), .phase(phase), .rd_en(rd_en), .rd_addr(rd_addr),
      .max_clr(max_clr), .max_en(max_en), .acc_clr(acc_clr), .acc_en(acc_en),
      .ln_start(ln_start), .wr_en(wr_en), .wr_addr(wr_addr)
   );

   softmax_seq_ctrl #(.SUM_LAT(4), .LN_LAT(3)) dut5 (
      .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks),
      .busy(busy5), .done(done5), .phase(phase5), .rd_en(rd_en5), .rd_addr(rd_addr5),
      .max_clr(max_clr5), .max_en(max_en5), .acc_clr(acc_clr5), .acc_en(acc_en5),
      .ln_start(ln_start5), .wr_en(wr_en5), .wr_addr(wr_addr5)
   );

   typedef struct packed {
      logic       rd_en;
      logic [3:0] rd_addr;
      logic       max_clr;
      logic       max_en;
      logic       acc_clr;
      logic       acc_en;
      logic       ln_start;
      logic       wr_en;
      logic [3:0] wr_addr;
      logic [1:0] phase;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      logic       start;
      logic [3:0] num;
      obs_t       exp;
   } vec_t;

   obs_t cur;
   assign cur = {rd_en, rd_addr, max_clr, max_en, acc_clr, acc_en, ln_start,
                 wr_en, wr_addr, phase, busy, done};

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic [3:0] n,
                               input logic rd, input logic [3:0] a,
                               input logic mclr, input logic men,
                               input logic aclr, input logic aen, input logic ln,
                               input logic wr, input logic [3:0] wa,
                               input logic [1:0] ph, input logic b, input logic d);
      vec_t v;
      v.start = s;
      v.num   = n;
      v.exp   = {rd, a, mclr, men, aclr, aen, ln, wr, wa, ph, b, d};
      return v;
   endfunction

   vec_t tbl [28];

   initial begin
      int rd_n, wr_n, done_n, done_cyc, bad_addr, busy_chk, nonzero, acc_n;
      int first_sum, first_acc, last_acc, ln_cyc, first_norm, d1, d2, max_addr;

      //          st n   rd a  mc me ac ae ln wr wa ph b  d
      tbl[0]  = mk(1, 4,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      tbl[2]  = mk(1, 9,  1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      tbl[3]  = mk(0, 0,  1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      tbl[4]  = mk(0, 0,  1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      tbl[5]  = mk(0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      tbl[6]  = mk(0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0);
      tbl[7]  = mk(0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      tbl[8]  = mk(0, 0,  1, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      tbl[9]  = mk(0, 0,  1, 3, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      tbl[10] = mk(0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      tbl[11] = mk(0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      tbl[12] = mk(0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      tbl[13] = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      tbl[14] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tbl[15] = mk(0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
      tbl[16] = mk(0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
      tbl[17] = mk(0, 0,  1, 2, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0);
      tbl[18] = mk(0, 0,  1, 3, 0, 0, 0, 0, 0, 1, 1, 3, 1, 0);
      tbl[19] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 0);
      tbl[20] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 1, 0);
      tbl[21] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      tbl[22] = mk(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // n == 0 run: single DONE cycle, then idle.
      tbl[23] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      tbl[24] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[25] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[26] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[27] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      reset = 1'b1;
      start = 1'b0;
      num_chunks = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         check($sformatf("vec row %0d", i), int'(cur), int'(tbl[i].exp));
         start      = tbl[i].start;
         num_chunks = tbl[i].num;
      end

      // n=1 with start and num_chunks=9 hammered during the run.
      @(negedge clk);
      start = 1'b1;
      num_chunks = 4'd1;
      rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; bad_addr = 0; busy_chk = -1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (rd_en) rd_n++;
         if (wr_en) wr_n++;
         if (rd_en && rd_addr != 4'd0) bad_addr++;
         if (wr_en && wr_addr != 4'd0) bad_addr++;
         if (done) begin done_n++; done_cyc = k; end
         if (k == 13) busy_chk = int'(busy);
         start = (k <= 11);
         num_chunks = 4'd9;
      end
      check("n1 done cycle", done_cyc, 12);
      check("n1 done count", done_n, 1);
      check("n1 rd_en count", rd_n, 3);
      check("n1 wr_en count", wr_n, 1);
      check("n1 addresses", bad_addr, 0);
      check("n1 idle after done", busy_chk, 0);

      // n=4 run aborted by reset late in cycle 8.
      @(negedge clk);
      start = 1'b1;
      num_chunks = 4'd4;
      nonzero = 0; acc_n = 0; wr_n = 0; done_n = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 7) check("abort pre-reset rd_addr", int'({rd_en, rd_addr}), 'h11);
         if (k >= 9) begin
            if (cur != '0) nonzero++;
            if (acc_en) acc_n++;
            if (wr_en) wr_n++;
            if (done) done_n++;
         end
         if (k == 8) reset = 1'b1;
         if (k == 9) reset = 1'b0;
      end
      check("abort outputs zero", nonzero, 0);
      check("abort acc_en", acc_n, 0);
      check("abort wr_en", wr_n, 0);
      check("abort done", done_n, 0);

      // Longer SUM and LN latencies on the second instance, n=2.
      @(negedge clk);
      start = 1'b1;
      num_chunks = 4'd2;
      first_sum = -1; first_acc = -1; last_acc = -1; ln_cyc = -1;
      first_norm = -1; acc_n = 0; done_cyc = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (rd_en5 && phase5 == 2'd2 && first_sum < 0) first_sum = k;
         if (acc_en5) begin
            acc_n++;
            if (first_acc < 0) first_acc = k;
            last_acc = k;
         end
         if (ln_start5) ln_cyc = k;
         if (rd_en5 && phase5 == 2'd3 && first_norm < 0) first_norm = k;
         if (done5) done_cyc = k;
      end
      check("lat first SUM rd", first_sum, 4);
      check("lat acc trails rd", first_acc - first_sum, 5);
      check("lat acc count", acc_n, 2);
      check("lat ln after acc", ln_cyc - last_acc, 1);
      check("lat ln cycle", ln_cyc, 11);
      check("lat norm after ln", first_norm - ln_cyc, 4);
      check("lat done cycle", done_cyc, 19);

      // n=15 with start held: two back-to-back runs.
      @(negedge clk);
      start = 1'b1;
      num_chunks = 4'd15;
      d1 = -1; d2 = -1; done_n = 0; busy_chk = -1; max_addr = 0;
      for (int k = 1; k <= 112; k++) begin
         @(negedge clk);
         if (done) begin
            done_n++;
            if (d1 < 0) d1 = k; else d2 = k;
         end
         if (rd_en && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
         if (k == 55) busy_chk = int'(busy);
         if (k == 111) check("max idle at end", int'(busy), 0);
         if (k == 109) start = 1'b0;
      end
      check("max first done", d1, 54);
      check("max second done", d2, 109);
      check("max done count", done_n, 2);
      check("max gap idle", busy_chk, 0);
      check("max top rd_addr", max_addr, 14);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
